// File: rtl/bcd2bin_sync.sv
// Serial reverse double-dabble: packed BCD in, unsigned binary out, one bit per clock.
// Define BCD_CHECK_EN to reject inputs with a digit above 9 (done+err pulse, bin_out held).
module bcd2bin_sync #(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {StIdle, StShift, StFinish} state_e;

    state_e            state_q, state_d;
    logic [BcdW-1:0]   bcd_q, bcd_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]  out_q, out_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              bad_q, bad_d;

    logic [BcdW+BIN_W-1:0] cat_sh;
    logic [BcdW-1:0]       bcd_fix;
    logic                  in_bad;

`ifdef BCD_CHECK_EN
    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) in_bad = 1'b1;
        end
    end
`else
    assign in_bad = 1'b0;
`endif

    // One iteration: shift the pair right, then pull every digit >= 8 back by 3.
    always_comb begin
        cat_sh  = {bcd_q, bin_q} >> 1;
        bcd_fix = cat_sh[BIN_W +: BcdW];
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_fix[4*i +: 4] >= 4'd8) bcd_fix[4*i +: 4] = bcd_fix[4*i +: 4] - 4'd3;
        end
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        bad_d   = bad_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    bcd_d   = bcd_in;
                    bin_d   = '0;
                    cnt_d   = CntW'(BIN_W);
                    bad_d   = in_bad;
                    state_d = in_bad ? StFinish : StShift;
                end
            end
            StShift: begin
                bcd_d = bcd_fix;
                bin_d = cat_sh[BIN_W-1:0];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) state_d = StFinish;
            end
            StFinish: begin
                done_d  = 1'b1;
                err_d   = bad_q;
                if (!bad_q) out_d = bin_q;
                bad_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            bcd_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
            err_q   <= err_d;
            bad_q   <= bad_d;
        end
    end

    assign bin_out = out_q;
    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_bcd2bin_sync.sv
// Bench for bcd2bin_sync: directed handshake cases plus random BCD values against a decimal model,
// on a 2-digit instance and a 3-digit instance.
module tb_bcd2bin_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic        start2, start3;
    logic [7:0]  bcd2;
    logic [11:0] bcd3;
    logic [6:0]  bin2;
    logic [9:0]  bin3;
    logic        busy2, done2, err2;
    logic        busy3, done3, err3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd2bin_sync #(.DIGITS(2), .BIN_W(7)) u_dut2 (
        .clk     (clk),
        .rst     (rst),
        .start   (start2),
        .bcd_in  (bcd2),
        .bin_out (bin2),
        .busy    (busy2),
        .done    (done2),
        .err     (err2)
    );

    bcd2bin_sync #(.DIGITS(3), .BIN_W(10)) u_dut3 (
        .clk     (clk),
        .rst     (rst),
        .start   (start3),
        .bcd_in  (bcd3),
        .bin_out (bin3),
        .busy    (busy3),
        .done    (done3),
        .err     (err3)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Decimal value of a packed BCD word, most significant digit first.
    function automatic int bcd_value(input logic [11:0] v, input int nd);
        int r = 0;
        for (int i = nd - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    task automatic wait_done2(input string tag, input int exp_lat);
        logic [6:0] prev = bin2;
        int changed = 0;
        int n = 0;
        while (done2 !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done2 !== 1'b1 && bin2 !== prev) changed = 1;
        end
        check_eq({tag, "_lat"}, n, exp_lat);
        check_eq({tag, "_hold"}, changed, 0);
    endtask

    task automatic count_dones2(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done2 === 1'b1) seen++;
        end
        check_eq({tag, "_nodone"}, seen, 0);
    endtask

    task automatic run2(input string tag, input logic [7:0] v, input int exp_lat,
                        input int exp_err, input int chk_val, input int exp_val);
        bcd2   = v;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        bcd2   = 8'($urandom);
        check_eq({tag, "_busy"}, int'(busy2), 1);
        wait_done2(tag, exp_lat);
        check_eq({tag, "_err"}, int'(err2), exp_err);
        check_eq({tag, "_idle"}, int'(busy2), 0);
        if (chk_val != 0) check_eq({tag, "_val"}, int'(bin2), exp_val);
        @(posedge clk);
        #1;
        check_eq({tag, "_pulse"}, int'(done2), 0);
    endtask

    task automatic run3(input string tag, input logic [11:0] v);
        int n = 0;
        bcd3   = v;
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        bcd3   = 12'($urandom);
        while (done3 !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq({tag, "_lat"}, n, 11);
        check_eq({tag, "_val"}, int'(bin3), bcd_value(v, 3));
        check_eq({tag, "_err"}, int'(err3), 0);
    endtask

    initial begin
        logic [7:0]  v2;
        logic [11:0] v3;
        rst    = 1'b0;
        start2 = 1'b0;
        start3 = 1'b0;
        bcd2   = '0;
        bcd3   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_bin", int'(bin2), 0);
        check_eq("rst_busy", int'(busy2), 0);
        check_eq("rst_done", int'(done2), 0);
        check_eq("rst_err", int'(err2), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        run2("c99", 8'h99, 8, 0, 1, 99);

        // Start held high: three conversions back to back, done pulses 9 cycles apart.
        bcd2   = 8'h00;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        bcd2 = 8'h47;
        wait_done2("b2b0", 8);
        check_eq("b2b0_val", int'(bin2), 0);
        @(posedge clk);
        #1;
        bcd2 = 8'h10;
        check_eq("b2b0_pulse", int'(done2), 0);
        check_eq("b2b1_busy", int'(busy2), 1);
        wait_done2("b2b1", 8);
        check_eq("b2b1_val", int'(bin2), 47);
        @(posedge clk);
        #1;
        start2 = 1'b0;
        wait_done2("b2b2", 8);
        check_eq("b2b2_val", int'(bin2), 10);
        @(posedge clk);
        #1;

        // Start while busy is dropped.
        bcd2   = 8'h25;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bcd2   = 8'h88;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        wait_done2("ign", 5);
        check_eq("ign_val", int'(bin2), 25);
        count_dones2("ign", 12);
        run2("c88", 8'h88, 8, 0, 1, 88);

        // Reset mid-conversion.
        bcd2   = 8'h59;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rst_bin", int'(bin2), 0);
        check_eq("mid_rst_busy", int'(busy2), 0);
        check_eq("mid_rst_done", int'(done2), 0);
        check_eq("mid_rst_err", int'(err2), 0);
        rst = 1'b1;
        count_dones2("mid_rst", 12);
        run2("c07", 8'h07, 8, 0, 1, 7);

        run2("c33", 8'h33, 8, 0, 1, 33);
`ifdef BCD_CHECK_EN
        run2("bad5a", 8'h5A, 1, 1, 1, 33);
`else
        run2("bad5a", 8'h5A, 8, 0, 0, 0);
`endif

        for (int i = 0; i < 12; i++) begin
            v2[7:4] = 4'($urandom_range(9));
            v2[3:0] = 4'($urandom_range(9));
            run2("rnd2", v2, 8, 0, 1, bcd_value({4'h0, v2}, 2));
        end

        run3("c999", 12'h999);
        run3("c255", 12'h255);
        for (int i = 0; i < 6; i++) begin
            v3[11:8] = 4'($urandom_range(9));
            v3[7:4]  = 4'($urandom_range(9));
            v3[3:0]  = 4'($urandom_range(9));
            run3("rnd3", v3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
